// File: rtl/clkdiv_multi_pkg.sv
// clkdiv_multi shared definitions.
// Odd-divisor duty modes and the post-reset divisor.
package clkdiv_multi_pkg;

  localparam int ODD50_OFF  = 0;
  localparam int ODD50_ON   = 1;
  localparam int D_INIT_DEF = 2;

endpackage

// File: rtl/clkdiv_multi_if.sv
// clkdiv_multi divisor load port.
// valid/ready handshake carrying target channel and divisor.
interface clkdiv_multi_if #(
  parameter int CHW   = 1,
  parameter int WIDTH = 16
);
  logic             ld_valid;
  logic             ld_ready;
  logic [CHW-1:0]   ld_ch;
  logic [WIDTH-1:0] ld_div;

  modport master (
    output ld_valid,
    output ld_ch,
    output ld_div,
    input  ld_ready
  );

  modport slave (
    input  ld_valid,
    input  ld_ch,
    input  ld_div,
    output ld_ready
  );
endinterface

// File: rtl/clkdiv_multi_chan.sv
// clkdiv_multi single channel.
// Period counter, shadowed divisor, negedge duty stage.
module clkdiv_multi_chan
  import clkdiv_multi_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int D_INIT = D_INIT_DEF,
  parameter int ODD50  = ODD50_ON
) (
  input  logic             clk,
  input  logic             nRST,
  input  logic             en,
  input  logic             sync,
  input  logic             ld,
  input  logic [WIDTH-1:0] ld_div,
  output logic             pending,
  output logic             clkout,
  output logic             tick
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  localparam logic [WIDTH-1:0] DI  = WIDTH'(D_INIT);
  localparam logic [WIDTH-1:0] CI  =
    (D_INIT == 0) ? '0 : WIDTH'(D_INIT - 1);

  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] d_act;
  logic [WIDTH-1:0] shadow;
  logic [WIDTH-1:0] d_eff;
  logic [WIDTH:0]   h;
  logic [WIDTH:0]   nxt;
  logic             p;
  logic             q;
  logic             bnd;
  logic             go;

  assign d_eff = pending ? shadow : d_act;
  assign bnd   = (d_act == '0)
               || (cnt == d_act - ONE)
               || (sync && en);
  assign go    = en && (d_eff != '0);
  assign nxt   = {1'b0, cnt} + (WIDTH+1)'(1);
  assign h     = ({1'b0, d_act} + (WIDTH+1)'(1)) >> 1;

  // idle keeps cnt at the last slot so the boundary re-checks
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      cnt     <= CI;
      d_act   <= DI;
      shadow  <= '0;
      pending <= 1'b0;
      p       <= 1'b0;
      tick    <= 1'b0;
    end else begin
      if (bnd) begin
        d_act   <= d_eff;
        pending <= 1'b0;
        if (go) begin
          cnt  <= '0;
          p    <= 1'b1;
          tick <= 1'b1;
        end else begin
          cnt  <= (d_eff == '0) ? '0 : d_eff - ONE;
          p    <= 1'b0;
          tick <= 1'b0;
        end
      end else begin
        cnt  <= cnt + ONE;
        p    <= (nxt < h);
        tick <= 1'b0;
      end
      if (ld) begin
        shadow  <= ld_div;
        pending <= 1'b1;
      end
    end
  end

  always_ff @(negedge clk or negedge nRST) begin
    if (!nRST) q <= 1'b0;
    else       q <= p;
  end

  assign clkout = (ODD50 != ODD50_OFF && d_act[0]) ? (p & q) : p;

endmodule

// File: rtl/clkdiv_multi.sv
// clkdiv_multi top: NCH programmable dividers.
// Decodes the load port onto channels and muxes ld_ready.
module clkdiv_multi
  import clkdiv_multi_pkg::*;
#(
  parameter int NCH    = 2,
  parameter int WIDTH  = 16,
  parameter int CHW    = 1,
  parameter int D_INIT = D_INIT_DEF,
  parameter int ODD50  = ODD50_ON
) (
  input  logic              clk,
  input  logic              nRST,
  input  logic [NCH-1:0]    en,
  input  logic              sync,
  clkdiv_multi_if.slave     ldp,
  output logic [NCH-1:0]    clkout,
  output logic [NCH-1:0]    tick
);

  logic [NCH-1:0] pend;
  logic [NCH-1:0] hit;

  // out-of-range channels read as ready so requests drain
  always_comb begin
    ldp.ld_ready = 1'b1;
    hit          = '0;
    for (int i = 0; i < NCH; i++) begin
      if (ldp.ld_ch == CHW'(i)) begin
        ldp.ld_ready = ~pend[i];
        hit[i]       = ldp.ld_valid & ~pend[i];
      end
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    clkdiv_multi_chan #(
      .WIDTH  (WIDTH),
      .D_INIT (D_INIT),
      .ODD50  (ODD50)
    ) u_ch (
      .clk     (clk),
      .nRST    (nRST),
      .en      (en[i]),
      .sync    (sync),
      .ld      (hit[i]),
      .ld_div  (ldp.ld_div),
      .pending (pend[i]),
      .clkout  (clkout[i]),
      .tick    (tick[i])
    );
  end

endmodule

// File: tb/tb_clkdiv_multi.sv
// tb_clkdiv_multi: scoreboard bench with a period-position model.
// Two DUTs (odd 50% and odd split duty) share all stimulus.
module tb_clkdiv_multi;
  import clkdiv_multi_pkg::*;

  localparam int NCH = 2;
  localparam int W   = 16;
  localparam int CHW = 2;
  localparam int DI  = 2;

  logic clk = 1'b0;
  logic nRST = 1'b0;
  logic [NCH-1:0] en = '0;
  logic sync = 1'b0;
  logic [NCH-1:0] clk_a, tick_a, clk_b, tick_b;

  always #5 clk = ~clk;

  clkdiv_multi_if #(.CHW(CHW), .WIDTH(W)) ifa ();
  clkdiv_multi_if #(.CHW(CHW), .WIDTH(W)) ifb ();

  clkdiv_multi #(
    .NCH(NCH), .WIDTH(W), .CHW(CHW), .D_INIT(DI), .ODD50(ODD50_ON)
  ) dut_a (
    .clk(clk), .nRST(nRST), .en(en), .sync(sync),
    .ldp(ifa), .clkout(clk_a), .tick(tick_a)
  );

  clkdiv_multi #(
    .NCH(NCH), .WIDTH(W), .CHW(CHW), .D_INIT(DI), .ODD50(ODD50_OFF)
  ) dut_b (
    .clk(clk), .nRST(nRST), .en(en), .sync(sync),
    .ldp(ifb), .clkout(clk_b), .tick(tick_b)
  );

  typedef struct {
    logic [7:0]     rdy;
    logic [NCH-1:0] tk;
    logic [NCH-1:0] ca;
    logic [NCH-1:0] cm;
    logic [NCH-1:0] cb;
  } exp_t;

  exp_t q[$];
  int nvec = 0;
  int nbad = 0;

  // model: divisor, shadow, position within the running period
  int md[NCH];
  int msh[NCH];
  int mpos[NCH];
  bit mpend[NCH];
  bit mrun[NCH];
  bit mhi[NCH];

  task automatic chk(input string nm, input logic [7:0] act,
                     input logic [7:0] expv);
    nvec++;
    if (act !== expv) begin
      nbad++;
      $display("FAIL %s t=%0t got %b want %b", nm, $time, act, expv);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      md[c] = DI; msh[c] = 0; mpos[c] = 0;
      mpend[c] = 0; mrun[c] = 0; mhi[c] = 0;
    end
  endtask

  task automatic step(input logic [NCH-1:0] en_i, input bit sync_i,
                      input bit v, input int ch, input int div);
    exp_t e;
    bit acc, bnd, prev;
    nRST = 1'b1;
    en = en_i;
    sync = sync_i;
    ifa.ld_valid = v; ifa.ld_ch = CHW'(ch); ifa.ld_div = W'(div);
    ifb.ld_valid = v; ifb.ld_ch = CHW'(ch); ifb.ld_div = W'(div);
    e.rdy = (ch >= NCH) ? 8'd1 : 8'(!mpend[ch]);
    for (int c = 0; c < NCH; c++) begin
      acc  = v && ch == c && !mpend[c];
      prev = mhi[c];
      bnd  = !mrun[c] || mpos[c] == md[c] - 1 || (sync_i && en_i[c]);
      e.tk[c] = 1'b0;
      if (bnd) begin
        if (mpend[c]) begin md[c] = msh[c]; mpend[c] = 0; end
        if (en_i[c] && md[c] >= 1) begin
          mrun[c] = 1; mpos[c] = 0; e.tk[c] = 1'b1;
        end else mrun[c] = 0;
      end else mpos[c]++;
      if (acc) begin msh[c] = div; mpend[c] = 1; end
      mhi[c] = mrun[c] && mpos[c] < (md[c] + 1) / 2;
      e.cm[c] = mhi[c];
      e.cb[c] = mhi[c];
      e.ca[c] = (md[c] % 2 == 1) ? (mhi[c] & prev) : mhi[c];
    end
    q.push_back(e);
  endtask

  task automatic cyc(input logic [NCH-1:0] en_i, input bit sync_i,
                     input bit v, input int ch, input int div);
    @(negedge clk); #2;
    step(en_i, sync_i, v, ch, div);
  endtask

  task automatic idle(input int n, input logic [NCH-1:0] en_i);
    for (int k = 0; k < n; k++) cyc(en_i, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk); #2;
    nRST = 1'b0;
    model_reset();
    #1;
    chk("rst_clk_a", 8'(clk_a), 8'd0);
    chk("rst_clk_b", 8'(clk_b), 8'd0);
    chk("rst_tick_a", 8'(tick_a), 8'd0);
    chk("rst_tick_b", 8'(tick_b), 8'd0);
    chk("rst_ready", 8'(ifa.ld_ready), 8'd1);
  endtask

  initial begin : monitor
    exp_t e, pe;
    bit hp;
    hp = 0;
    forever begin
      @(negedge clk); #1;
      if (hp) begin
        chk("clk_mid_a", 8'(clk_a), 8'(pe.cm));
        chk("clk_mid_b", 8'(clk_b), 8'(pe.cm));
      end
      #3;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("ready_a", 8'(ifa.ld_ready), e.rdy);
        chk("ready_b", 8'(ifb.ld_ready), e.rdy);
        @(posedge clk); #1;
        chk("tick_a", 8'(tick_a), 8'(e.tk));
        chk("tick_b", 8'(tick_b), 8'(e.tk));
        chk("clk_a", 8'(clk_a), 8'(e.ca));
        chk("clk_b", 8'(clk_b), 8'(e.cb));
        pe = e;
        hp = 1;
      end else hp = 0;
    end
  end

  initial begin : driver
    ifa.ld_valid = 0; ifa.ld_ch = '0; ifa.ld_div = '0;
    ifb.ld_valid = 0; ifb.ld_ch = '0; ifb.ld_div = '0;
    model_reset();
    #1;
    do_reset();
    // D=4 on ch0, run the 1,1,0,0 pattern
    cyc(2'b11, 0, 1, 0, 4);
    idle(12, 2'b11);
    // load 6 mid-period, hold valid to see ready low
    cyc(2'b11, 0, 1, 0, 6);
    cyc(2'b11, 0, 1, 0, 6);
    idle(14, 2'b11);
    // odd divisor
    cyc(2'b11, 0, 1, 0, 3);
    idle(12, 2'b11);
    // en drop in a D=8 period, then re-enable
    cyc(2'b11, 0, 1, 0, 8);
    idle(9, 2'b11);
    idle(14, 2'b10);
    idle(5, 2'b11);
    // sync alignment of D=4 and D=6
    cyc(2'b11, 0, 1, 0, 4);
    cyc(2'b11, 0, 1, 1, 6);
    idle(8, 2'b11);
    cyc(2'b11, 1, 0, 0, 0);
    idle(26, 2'b11);
    // D=0 then D=2, out-of-range loads
    cyc(2'b11, 0, 1, 0, 0);
    idle(8, 2'b11);
    cyc(2'b11, 0, 1, 0, 2);
    idle(6, 2'b11);
    cyc(2'b11, 0, 1, 3, 5);
    cyc(2'b11, 0, 1, 2, 7);
    idle(4, 2'b11);
    cyc(2'b11, 0, 1, 1, 1);
    idle(5, 2'b11);
    cyc(2'b11, 0, 1, 1, 5);
    idle(12, 2'b11);
    for (int k = 0; k < 4000; k++) begin
      logic [NCH-1:0] er;
      int dv;
      if (k == 2000) do_reset();
      for (int c = 0; c < NCH; c++)
        er[c] = ($urandom_range(0, 99) < 85);
      dv = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 40))
                                        : int'($urandom_range(0, 9));
      cyc(er, $urandom_range(0, 29) == 0, $urandom_range(0, 5) == 0,
          int'($urandom_range(0, 3)), dv);
    end
    idle(3, 2'b11);
    @(negedge clk); #6;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
